// File: rtl/fp_pkg.sv
// Shared single-precision constants, FSM state type and operand classification for fdiv.
// Classification treats exponent 0 as zero, so denormal inputs are flushed to signed zero.
package fp_pkg;

    localparam int          FP_EXP_BIAS = 127;
    localparam logic [31:0] FP_QNAN     = 32'h7FC00000;
    localparam logic [31:0] FP_POS_INF  = 32'h7F800000;
    localparam int          FP_DIV_ITER = 25;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_CALC,
        ST_NORM,
        ST_DONE
    } fdiv_state_t;

    typedef struct packed {
        logic is_zero;
        logic is_inf;
        logic is_nan;
    } fp_class_t;

    function automatic fp_class_t fp_classify(input logic [31:0] f);
        fp_class_t c;
        c.is_zero = (f[30:23] == 8'h00);
        c.is_inf  = (f[30:23] == 8'hFF) && (f[22:0] == 23'd0);
        c.is_nan  = (f[30:23] == 8'hFF) && (f[22:0] != 23'd0);
        return c;
    endfunction

endpackage

// File: rtl/fdiv_if.sv
// Request/response bundle of the divider: one-cycle start with operands in, registered result with busy/done out.
// No backpressure: the requester must watch busy/done, starts outside IDLE are dropped.
interface fdiv_if;
    logic        start;
    logic [31:0] operand1;
    logic [31:0] operand2;
    logic [31:0] result;
    logic        busy;
    logic        done;

    modport master (output start, operand1, operand2, input result, busy, done);
    modport slave  (input start, operand1, operand2, output result, busy, done);
endinterface

// File: rtl/fdiv_mant_div.sv
// Restoring mantissa divider: one quotient bit per step, MSB first, 25 steps for q[24:0] = floor(ma/mb * 2^24).
// Loaded in one cycle; advances only while step is high; last flags the final step.
module fdiv_mant_div
    import fp_pkg::*;
(
    input  logic        clk,
    input  logic        rst_n,
    input  logic        load,
    input  logic        step,
    input  logic [23:0] ma,
    input  logic [23:0] mb,
    output logic [24:0] q,
    output logic        last
);

    logic [25:0] rem;
    logic [23:0] div_q;
    logic [4:0]  cnt;
    logic [25:0] rem_sub;
    logic [25:0] rem_keep;
    logic        qbit;

    always_comb begin
        rem_sub  = rem - {2'b00, div_q};
        qbit     = (rem >= {2'b00, div_q});
        rem_keep = qbit ? rem_sub : rem;
    end

    assign last = step && (cnt == 5'(FP_DIV_ITER - 1));

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rem   <= '0;
            q     <= '0;
            cnt   <= '0;
            div_q <= '0;
        end else if (load) begin
            rem   <= {2'b00, ma};
            q     <= '0;
            cnt   <= '0;
            div_q <= mb;
        end else if (step) begin
            // Remainder stays below the divisor, so the doubled value always fits 26 bits.
            rem <= rem_keep << 1;
            q   <= {q[23:0], qbit};
            cnt <= cnt + 5'd1;
        end
    end

endmodule

// File: rtl/fdiv.sv
// IEEE-754 single divider, truncating, no denormal output: specials finish 1 cycle after Start, normal path 27.
// Start is honoured only in IDLE; there is no queueing, so requests during CALC/NORM/DONE are lost.
module fdiv
    import fp_pkg::*;
(
    input  logic   clk,
    input  logic   rst_n,
    fdiv_if.slave  io
);

    fdiv_state_t state;
    fp_class_t   c1;
    fp_class_t   c2;
    logic        sign_in;
    logic        spec_hit;
    logic [31:0] spec_res;
    logic        sign_q;
    logic [7:0]  e1_q;
    logic [7:0]  e2_q;
    logic [24:0] div_q;
    logic        div_last;
    logic        div_load;
    logic signed [9:0] exp_n;
    logic [22:0] mant_n;
    logic [31:0] norm_res;

    assign c1      = fp_classify(io.operand1);
    assign c2      = fp_classify(io.operand2);
    assign sign_in = io.operand1[31] ^ io.operand2[31];

    always_comb begin
        spec_hit = 1'b1;
        spec_res = FP_QNAN;
        if (c1.is_nan || c2.is_nan || (c1.is_zero && c2.is_zero) || (c1.is_inf && c2.is_inf))
            spec_res = FP_QNAN;
        else if (c1.is_inf || c2.is_zero)
            spec_res = {sign_in, FP_POS_INF[30:0]};
        else if (c1.is_zero || c2.is_inf)
            spec_res = {sign_in, 31'd0};
        else
            spec_hit = 1'b0;
    end

    assign div_load = (state == ST_IDLE) && io.start && !spec_hit;

    fdiv_mant_div u_mant_div (
        .clk   (clk),
        .rst_n (rst_n),
        .load  (div_load),
        .step  (state == ST_CALC),
        .ma    ({1'b1, io.operand1[22:0]}),
        .mb    ({1'b1, io.operand2[22:0]}),
        .q     (div_q),
        .last  (div_last)
    );

    // A quotient below 1.0 carries its leading one in q[23], costing one exponent step.
    always_comb begin
        exp_n  = $signed({2'b00, e1_q}) - $signed({2'b00, e2_q}) + $signed(10'(FP_EXP_BIAS));
        mant_n = div_q[23:1];
        if (!div_q[24]) begin
            exp_n  = exp_n - 10'sd1;
            mant_n = div_q[22:0];
        end
        if (exp_n >= 10'sd255)
            norm_res = {sign_q, FP_POS_INF[30:0]};
        else if (exp_n <= 10'sd0)
            norm_res = {sign_q, 31'd0};
        else
            norm_res = {sign_q, exp_n[7:0], mant_n};
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= ST_IDLE;
            io.result <= '0;
            io.busy   <= 1'b0;
            io.done   <= 1'b0;
            sign_q    <= 1'b0;
            e1_q      <= '0;
            e2_q      <= '0;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (io.start) begin
                        sign_q <= sign_in;
                        e1_q   <= io.operand1[30:23];
                        e2_q   <= io.operand2[30:23];
                        if (spec_hit) begin
                            io.result <= spec_res;
                            io.done   <= 1'b1;
                            state     <= ST_DONE;
                        end else begin
                            io.busy <= 1'b1;
                            state   <= ST_CALC;
                        end
                    end
                end
                ST_CALC: begin
                    if (div_last)
                        state <= ST_NORM;
                end
                ST_NORM: begin
                    io.result <= norm_res;
                    io.busy   <= 1'b0;
                    io.done   <= 1'b1;
                    state     <= ST_DONE;
                end
                ST_DONE: begin
                    io.done <= 1'b0;
                    state   <= ST_IDLE;
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_fdiv.sv
// Scoreboarded bench for fdiv: directed corner cases plus random operands against an integer-arithmetic model.
module tb_fdiv;

    logic clk = 1'b0;
    logic rst_n;
    int   cyc = 0;
    int   n_cmp = 0;
    int   n_bad = 0;

    typedef struct {
        logic [31:0] res;
        int          lat;
        int          t0;
    } exp_t;

    exp_t sbq[$];

    fdiv_if io ();

    fdiv dut (
        .clk   (clk),
        .rst_n (rst_n),
        .io    (io)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] want);
        n_cmp++;
        if (act !== want) begin
            n_bad++;
            $display("FAIL %s: got %h, want %h (cycle %0d)", name, act, want, cyc);
        end
    endtask

    // Reference: classify, then divide the 24-bit significands with plain integer division.
    function automatic void ref_div(input logic [31:0] a, input logic [31:0] b,
                                    output logic [31:0] r, output int lat);
        logic   s;
        int     ea, eb, e;
        logic   za, zb, ia, ib, na, nb;
        longint ma, mb, q;
        s  = a[31] ^ b[31];
        ea = int'(a[30:23]);
        eb = int'(b[30:23]);
        za = (ea == 0);
        zb = (eb == 0);
        ia = (ea == 255) && (a[22:0] == 23'd0);
        ib = (eb == 255) && (b[22:0] == 23'd0);
        na = (ea == 255) && (a[22:0] != 23'd0);
        nb = (eb == 255) && (b[22:0] != 23'd0);
        lat = 1;
        if (na || nb || (za && zb) || (ia && ib)) r = 32'h7FC00000;
        else if (ia || zb)                         r = {s, 8'hFF, 23'd0};
        else if (za || ib)                         r = {s, 31'd0};
        else begin
            lat = 27;
            ma = longint'(a[22:0]) + 64'sd8388608;
            mb = longint'(b[22:0]) + 64'sd8388608;
            q  = (ma * 64'sd16777216) / mb;
            if (q >= 64'sd16777216) begin
                q = q / 2;
                e = ea - eb + 127;
            end else begin
                e = ea - eb + 126;
            end
            if (e >= 255)    r = {s, 8'hFF, 23'd0};
            else if (e <= 0) r = {s, 31'd0};
            else             r = {s, 8'(e), 23'(q)};
        end
    endfunction

    function automatic logic [31:0] rand_fp();
        logic [7:0]  e;
        logic [22:0] f;
        int          k;
        k = $urandom_range(0, 9);
        f = 23'($urandom);
        case (k)
            0:       e = 8'h00;
            1:       e = 8'hFF;
            2:       e = 8'($urandom_range(1, 3));
            3:       e = 8'($urandom_range(252, 254));
            default: e = 8'($urandom_range(1, 254));
        endcase
        if ($urandom_range(0, 5) == 0) f = 23'd0;
        return {1'($urandom), e, f};
    endfunction

    // Drives Start for one cycle (optionally waiting for the next edge first) and books the expected response.
    task automatic issue(input logic [31:0] a, input logic [31:0] b, input bit sync);
        exp_t e;
        if (sync) begin
            @(posedge clk);
            #1;
        end
        io.operand1 = a;
        io.operand2 = b;
        io.start    = 1'b1;
        ref_div(a, b, e.res, e.lat);
        e.t0 = cyc;
        sbq.push_back(e);
        @(posedge clk);
        #1;
        io.start    = 1'b0;
        io.operand1 = $urandom;
        io.operand2 = $urandom;
    endtask

    task automatic wait_idle(input bit jab);
        int n;
        n = 0;
        while (sbq.size() > 0 && n < 60) begin
            @(posedge clk);
            #1;
            n++;
            if (jab && sbq.size() > 0 && $urandom_range(0, 7) == 0) begin
                io.start    = 1'b1;
                io.operand1 = $urandom;
                io.operand2 = $urandom;
                @(posedge clk);
                #1;
                io.start = 1'b0;
                n++;
            end
        end
        check("drain_outstanding", 32'(sbq.size()), 32'd0);
        sbq.delete();
    endtask

    always @(negedge clk) begin
        exp_t e;
        int   age;
        logic exp_busy;
        if (rst_n) begin
            exp_busy = 1'b0;
            if (sbq.size() > 0) begin
                age = cyc - sbq[0].t0;
                exp_busy = (sbq[0].lat == 27) && (age >= 1) && (age <= 26);
            end
            check("busy", 32'(io.busy), 32'(exp_busy));
            if (io.done) begin
                if (sbq.size() == 0) begin
                    check("done_unexpected", 32'(io.done), 32'd0);
                end else begin
                    e = sbq.pop_front();
                    check("result", io.result, e.res);
                    check("latency", 32'(cyc - e.t0), 32'(e.lat));
                end
            end else if (sbq.size() > 0 && (cyc - sbq[0].t0) >= sbq[0].lat) begin
                check("done_missing", 32'(io.done), 32'd1);
                void'(sbq.pop_front());
            end
        end
    end

    logic [31:0] dir_a [14] = '{32'h40C00000, 32'h3F800000, 32'hBF800000, 32'hBF800000,
                                32'h00000000, 32'h7F800000, 32'h7F000000, 32'h00800000,
                                32'h7FC01234, 32'hFF800000, 32'h00000000, 32'h40A00000,
                                32'h00123456, 32'h3F800000};
    logic [31:0] dir_b [14] = '{32'h40000000, 32'h40400000, 32'h3F000000, 32'h00000000,
                                32'h00000000, 32'h7F800000, 32'h3E800000, 32'h40000000,
                                32'h3F800000, 32'h40000000, 32'hC0A00000, 32'hFF800000,
                                32'h40000000, 32'h00654321};

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached, want completion");
        $fatal(1, "watchdog");
    end

    initial begin
        io.start    = 1'b0;
        io.operand1 = '0;
        io.operand2 = '0;
        rst_n       = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        check("reset_result", io.result, 32'd0);
        check("reset_busy", 32'(io.busy), 32'd0);
        check("reset_done", 32'(io.done), 32'd0);
        rst_n = 1'b1;

        for (int i = 0; i < 14; i++) begin
            issue(dir_a[i], dir_b[i], 1'b1);
            wait_idle(1'b0);
        end

        // A second Start at cycle 10 must not disturb the running 6/2.
        issue(32'h40C00000, 32'h40000000, 1'b1);
        repeat (9) @(posedge clk);
        #1;
        io.start    = 1'b1;
        io.operand1 = 32'h3F800000;
        io.operand2 = 32'h40400000;
        @(posedge clk);
        #1;
        io.start = 1'b0;
        wait_idle(1'b0);

        // Start during the Done cycle is dropped; the next IDLE cycle accepts.
        issue(32'hBF800000, 32'h00000000, 1'b1);
        io.start    = 1'b1;
        io.operand1 = 32'h3F800000;
        io.operand2 = 32'h40400000;
        @(posedge clk);
        #1;
        issue(32'h40C00000, 32'h40000000, 1'b0);
        wait_idle(1'b0);

        // Reset in the middle of a division.
        issue(32'h40C00000, 32'h40000000, 1'b1);
        repeat (9) @(posedge clk);
        #1;
        rst_n = 1'b0;
        sbq.delete();
        #1;
        check("midreset_busy", 32'(io.busy), 32'd0);
        check("midreset_done", 32'(io.done), 32'd0);
        check("midreset_result", io.result, 32'd0);
        repeat (2) @(posedge clk);
        #1;
        rst_n = 1'b1;
        issue(32'h40C00000, 32'h40000000, 1'b1);
        wait_idle(1'b0);

        repeat (150) begin
            issue(rand_fp(), rand_fp(), 1'b1);
            wait_idle(1'b1);
            repeat ($urandom_range(0, 2)) @(posedge clk);
        end

        repeat (5) @(posedge clk);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
